game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/ball_game_pkg.sv | 26 ++
 rtl/frame_tick_gen.sv | 31 +++
 rtl/game_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ball_game_pkg.sv
// -----------------------------------------------------------------------------
// ball_game_pkg
// Shared definitions for the ball game sequencer:
//   - state_t      : sequencer state encoding (3 bits, codes 6/7 unused)
//   - *_DEF        : default values for the game_sequencer parameters
//   - CNT_W/cnt_t  : width and type of the frame counter
// -----------------------------------------------------------------------------
package ball_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam int SERVE_FRAMES_DEF = 60;
    localparam int OVER_FRAMES_DEF  = 180;
    localparam int LOST_Y_DEF       = 240;

    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Produces a single-clk pulse on the rising edge of the (clk-synchronous)
// vertical sync level, i.e. once per video frame.
//   clk    in  clock
//   reset  in  asynchronous, active-high reset
//   vsync  in  vertical sync level, already synchronous to clk
//   tick   out one-cycle pulse when vsync rises
// -----------------------------------------------------------------------------
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic tick
);

    logic vsync_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= vsync;
        end
    end

    // Rising edge: low last cycle, high now. Cleared vsync_d at reset means a
    // vsync already high when reset releases counts as a new frame.
    assign tick = vsync & ~vsync_d;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Top-level game flow controller for the ball/brick game. Walks through
// idle -> serve -> play -> (lost | clear) -> serve ... -> over -> idle, pacing
// every step on video frames.
//
// Parameters:
//   SERVE_FRAMES  frames the ball is held at the serve position before launch
//   OVER_FRAMES   frames the game-over screen is shown
//   LOST_Y        ball_y at or beyond which the ball counts as lost
//
// Ports:
//   clk            in   system/pixel clock
//   reset          in   asynchronous, active-high reset
//   vsync          in   vertical sync level (clk-synchronous)
//   start          in   start button level
//   ball_y         in   [8:0] current ball Y position
//   bricks_left    in   [7:0] remaining bricks
//   lives          in   [3:0] life count from the stats block
//   state          out  [2:0] current state code (see ball_game_pkg)
//   ball_hold      out  freeze the ball at the serve position
//   declives       out  one-cycle pulse: decrement lives
//   newgame        out  one-cycle pulse: reload lives and score
//   bricks_reload  out  one-cycle pulse: refill the brick array
//   game_over      out  high while in the game-over state
//   demo           out  (ATTRACT_DEMO_EN only) high while in idle
//
// Build option:
//   ATTRACT_DEMO_EN  when defined, idle runs an attract-mode demo: the ball
//                    moves freely, a lost ball just refills the bricks, and
//                    the demo output is added.
//
// All outputs come straight from flops; pulses are registered together with
// the state change that causes them, so e.g. declives is high on the first
// cycle that state reads S_LOST.
// -----------------------------------------------------------------------------
module game_sequencer
    import ball_game_pkg::*;
#(
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int OVER_FRAMES  = OVER_FRAMES_DEF,
    parameter int LOST_Y       = LOST_Y_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       start,
    input  logic [8:0] ball_y,
    input  logic [7:0] bricks_left,
    input  logic [3:0] lives,
    output logic [2:0] state,
    output logic       ball_hold,
    output logic       declives,
    output logic       newgame,
    output logic       bricks_reload,
    output logic       game_over
`ifdef ATTRACT_DEMO_EN
    ,
    output logic       demo
`endif
);

`ifdef ATTRACT_DEMO_EN
    localparam logic DEMO_MODE = 1'b1;
`else
    localparam logic DEMO_MODE = 1'b0;
`endif

    localparam cnt_t       SERVE_LOAD = cnt_t'(SERVE_FRAMES - 1);
    localparam cnt_t       OVER_LOAD  = cnt_t'(OVER_FRAMES - 1);
    localparam logic [8:0] LOST_Y9    = 9'(LOST_Y);

    logic   frame_tick;
    logic   ball_lost;

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    // Remembers whether the ball was lost on the last life. Captured on the
    // tick that enters S_LOST, before the stats block applies declives.
    logic   last_life_q, last_life_d;

    logic   declives_d, newgame_d, reload_d;
    logic   hold_d;

    frame_tick_gen u_frame_tick (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .tick  (frame_tick)
    );

    assign ball_lost = (ball_y >= LOST_Y9);

    // ---------------- next-state and pulse decode ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_life_d = last_life_q;
        declives_d  = 1'b0;
        newgame_d   = 1'b0;
        reload_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Start is the one transition not paced by frames.
                if (start) begin
                    state_d   = S_SERVE;
                    cnt_d     = SERVE_LOAD;
                    newgame_d = 1'b1;
                    reload_d  = 1'b1;
                end else if (DEMO_MODE && frame_tick && ball_lost) begin
                    // Attract demo: a lost ball only refreshes the wall.
                    reload_d = 1'b1;
                end
            end

            S_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
            end

            S_PLAY: begin
                // Clearing the wall takes priority over a simultaneous loss,
                // so the last brick never costs a life.
                if (frame_tick) begin
                    if (bricks_left == 8'd0) begin
                        state_d  = S_CLEAR;
                        reload_d = 1'b1;
                    end else if (ball_lost) begin
                        state_d     = S_LOST;
                        declives_d  = 1'b1;
                        last_life_d = (lives <= 4'd1);
                    end
                end
            end

            S_LOST: begin
                if (frame_tick) begin
                    if (last_life_q) begin
                        state_d = S_OVER;
                        cnt_d   = OVER_LOAD;
                    end else begin
                        state_d = S_SERVE;
                        cnt_d   = SERVE_LOAD;
                    end
                end
            end

            S_CLEAR: begin
                if (frame_tick) begin
                    state_d = S_SERVE;
                    cnt_d   = SERVE_LOAD;
                end
            end

            S_OVER: begin
                if (frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
            end

            default: begin
                // Unused codes recover to idle immediately.
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        hold_d = (state_d != S_PLAY) && !(DEMO_MODE && (state_d == S_IDLE));
    end

    // ---------------- state and output registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_life_q   <= 1'b0;
            ball_hold     <= !DEMO_MODE;
            declives      <= 1'b0;
            newgame       <= 1'b0;
            bricks_reload <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_life_q   <= last_life_d;
            ball_hold     <= hold_d;
            declives      <= declives_d;
            newgame       <= newgame_d;
            bricks_reload <= reload_d;
            game_over     <= (state_d == S_OVER);
        end
    end

`ifdef ATTRACT_DEMO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            demo <= 1'b1;
        end else begin
            demo <= (state_d == S_IDLE);
        end
    end
`endif

    assign state = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Scoreboard bench for game_sequencer. Each driven cycle pushes the outputs
// expected after the next clock edge; they are popped and compared once the
// DUT has registered them. Frames are two clk cycles: vsync high (the tick
// cycle) then vsync low.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_LOST  = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

`ifdef ATTRACT_DEMO_EN
    localparam logic DEMO_MODE = 1'b1;
`else
    localparam logic DEMO_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       start;
    logic [8:0] ball_y;
    logic [7:0] bricks_left;
    logic [3:0] lives;
    logic [2:0] state;
    logic       ball_hold;
    logic       declives;
    logic       newgame;
    logic       bricks_reload;
    logic       game_over;
`ifdef ATTRACT_DEMO_EN
    logic       demo;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       hold;
        logic       dl;
        logic       ng;
        logic       rl;
        logic       go;
    } exp_t;

    exp_t sb[$];

    game_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .vsync         (vsync),
        .start         (start),
        .ball_y        (ball_y),
        .bricks_left   (bricks_left),
        .lives         (lives),
        .state         (state),
        .ball_hold     (ball_hold),
        .declives      (declives),
        .newgame       (newgame),
        .bricks_reload (bricks_reload),
        .game_over     (game_over)
`ifdef ATTRACT_DEMO_EN
        ,
        .demo          (demo)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected output vector for a given resulting state and pulse set.
    function automatic exp_t mk(input logic [2:0] st, input logic dl, input logic ng,
                                input logic rl);
        exp_t e;
        e.st   = st;
        e.hold = (st != ST_PLAY) && !(DEMO_MODE && (st == ST_IDLE));
        e.dl   = dl;
        e.ng   = ng;
        e.rl   = rl;
        e.go   = (st == ST_OVER);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("ball_hold", 32'(ball_hold), 32'(e.hold));
            chk("declives", 32'(declives), 32'(e.dl));
            chk("newgame", 32'(newgame), 32'(e.ng));
            chk("bricks_reload", 32'(bricks_reload), 32'(e.rl));
            chk("game_over", 32'(game_over), 32'(e.go));
`ifdef ATTRACT_DEMO_EN
            chk("demo", 32'(demo), 32'(e.st == ST_IDLE));
`endif
        end
    endtask

    task automatic cyc(input logic v, input exp_t e);
        vsync = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic frame(input logic [2:0] st, input logic dl, input logic ng, input logic rl);
        cyc(1'b1, mk(st, dl, ng, rl));
        cyc(1'b0, mk(st, 1'b0, 1'b0, 1'b0));
    endtask

    // Serve hold: launch on exactly the 60th frame tick after entry.
    task automatic serve_to_play();
        for (int i = 1; i <= 60; i++) begin
            frame((i == 60) ? ST_PLAY : ST_SERVE, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        vsync       = 1'b0;
        start       = 1'b0;
        ball_y      = 9'd100;
        bricks_left = 8'd50;
        lives       = 4'd3;

        // Reset state
        #12;
        sb.push_back(mk(ST_IDLE, 1'b0, 1'b0, 1'b0));
        compare_out();
        @(posedge clk);
        #1;
        reset = 1'b0;

        cyc(1'b0, mk(ST_IDLE, 1'b0, 1'b0, 1'b0));
        cyc(1'b0, mk(ST_IDLE, 1'b0, 1'b0, 1'b0));

        // Ball loss while idle: refills the wall only in the demo build
        ball_y = 9'd240;
        cyc(1'b1, mk(ST_IDLE, 1'b0, 1'b0, DEMO_MODE));
        ball_y = 9'd100;
        cyc(1'b0, mk(ST_IDLE, 1'b0, 1'b0, 1'b0));

        // Start: newgame + bricks_reload together, then serve countdown
        start = 1'b1;
        cyc(1'b0, mk(ST_SERVE, 1'b0, 1'b1, 1'b1));
        start = 1'b0;
        cyc(1'b0, mk(ST_SERVE, 1'b0, 1'b0, 1'b0));
        serve_to_play();

        // Play: below-threshold, exact threshold off-tick, then loss (lives=3)
        frame(ST_PLAY, 1'b0, 1'b0, 1'b0);
        ball_y = 9'd239;
        frame(ST_PLAY, 1'b0, 1'b0, 1'b0);
        ball_y = 9'd240;
        cyc(1'b0, mk(ST_PLAY, 1'b0, 1'b0, 1'b0));
        frame(ST_LOST, 1'b1, 1'b0, 1'b0);
        lives  = 4'd2;
        ball_y = 9'd100;
        frame(ST_SERVE, 1'b0, 1'b0, 1'b0);

        // From here start is held; it must be ignored until idle again
        start = 1'b1;
        serve_to_play();

        // Clear and loss on the same tick: clear wins, no declives
        bricks_left = 8'd0;
        ball_y      = 9'd245;
        frame(ST_CLEAR, 1'b0, 1'b0, 1'b1);
        bricks_left = 8'd50;
        ball_y      = 9'd100;
        frame(ST_SERVE, 1'b0, 1'b0, 1'b0);
        serve_to_play();

        // Loss with lives=2; stats block then shows 1, but the pre-decrement
        // count decides, so the game continues
        ball_y = 9'd255;
        frame(ST_LOST, 1'b1, 1'b0, 1'b0);
        lives  = 4'd1;
        ball_y = 9'd100;
        frame(ST_SERVE, 1'b0, 1'b0, 1'b0);
        serve_to_play();

        // Last life lost: game over for 180 frames, then idle
        ball_y = 9'd250;
        frame(ST_LOST, 1'b1, 1'b0, 1'b0);
        lives  = 4'd0;
        ball_y = 9'd100;
        frame(ST_OVER, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 180; i++) begin
            if (i == 180) start = 1'b0;
            frame((i == 180) ? ST_IDLE : ST_OVER, 1'b0, 1'b0, 1'b0);
        end

        // New game, then reset in the middle of play
        lives = 4'd3;
        start = 1'b1;
        cyc(1'b0, mk(ST_SERVE, 1'b0, 1'b1, 1'b1));
        start = 1'b0;
        cyc(1'b0, mk(ST_SERVE, 1'b0, 1'b0, 1'b0));
        serve_to_play();
        frame(ST_PLAY, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(mk(ST_IDLE, 1'b0, 1'b0, 1'b0));
        compare_out();
        @(posedge clk);
        #1;
        sb.push_back(mk(ST_IDLE, 1'b0, 1'b0, 1'b0));
        compare_out();
        reset = 1'b0;
        cyc(1'b0, mk(ST_IDLE, 1'b0, 1'b0, 1'b0));
        cyc(1'b1, mk(ST_IDLE, 1'b0, 1'b0, 1'b0));
        cyc(1'b0, mk(ST_IDLE, 1'b0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
